// File: rtl/seq_muldiv.sv
// Sequential multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with fixed latency of WIDTH+1 cycles from accepted start to done.
module seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH:0]   r_acc;
  logic [WIDTH-1:0]   r_mb;
  logic [WIDTH-1:0]   r_a;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_bzero;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed_op;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;
  logic               w_accept;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH:0]   w_mul_next;
  logic [WIDTH+1:0]   w_div_shift;
  logic [WIDTH+1:0]   w_div_diff;
  logic [2*WIDTH:0]   w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // Operands are reduced to magnitudes up front; -2^(WIDTH-1) maps onto itself,
  // which is its correct unsigned magnitude.
  assign w_signed_op = ~op[0];
  assign w_a_neg     = w_signed_op & a[WIDTH-1];
  assign w_b_neg     = w_signed_op & b[WIDTH-1];
  assign w_ma        = w_a_neg ? -a : a;
  assign w_mb        = w_b_neg ? -b : b;

  // The result cycle also accepts a new request so ops can run back to back.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_FIX));

  // Multiply step: accumulator is {carry, upper half, multiplier bits}.
  assign w_mul_sum  = r_acc[0] ? (r_acc[2*WIDTH:WIDTH] + {1'b0, r_mb}) : r_acc[2*WIDTH:WIDTH];
  assign w_mul_next = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide step: accumulator is {partial remainder, dividend/quotient bits}.
  assign w_div_shift = {r_acc[2*WIDTH:WIDTH], r_acc[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {2'b00, r_mb};
  assign w_div_next  = w_div_diff[WIDTH+1]
                     ? {w_div_shift[WIDTH:0], r_acc[WIDTH-2:0], 1'b0}
                     : {w_div_diff[WIDTH:0],  r_acc[WIDTH-2:0], 1'b1};

  assign w_prod_fix = r_neg_q ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
  assign w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mb     <= '0;
      r_a      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bzero  <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) r_state <= S_FIX;
        end
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          if (!r_is_div) begin
            {r_hi, r_lo} <= w_prod_fix;
          end else if (r_bzero) begin
            r_hi <= r_a;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: ;
      endcase

      // Placed after the case so a request taken in the result cycle wins the state.
      if (w_accept) begin
        r_state  <= op[1] ? S_DIV : S_MUL;
        r_cnt    <= '0;
        r_acc    <= {{(WIDTH+1){1'b0}}, w_ma};
        r_mb     <= w_mb;
        r_a      <= a;
        r_is_div <= op[1];
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        r_bzero  <= (b == '0);
      end
    end
  end

  // busy is masked in the done cycle, including when a new op was just accepted.
  assign busy = (r_state != S_IDLE) && !r_done;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_seq_muldiv.sv
// Scoreboard bench for seq_muldiv (WIDTH=32): the driver queues expected results,
// a negedge monitor pops and compares them whenever done is seen.
module tb_seq_muldiv;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           done_at;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  seq_muldiv #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  // Edge k leaves cyc == k+1; a reader right after the edge still sees k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      check("busy_clear_with_done", 64'(busy), 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_hi"}, 64'(hi), 64'(mon_e.hi));
        check({mon_e.name, "_lo"}, 64'(lo), 64'(mon_e.lo));
        check({mon_e.name, "_done_edge"}, 64'(cyc - 1), 64'(mon_e.done_at));
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] eh, input logic [W-1:0] el,
                          input int at, input string nm);
    exp_t e;
    e.hi      = eh;
    e.lo      = el;
    e.done_at = at;
    e.name    = nm;
    sb.push_back(e);
  endtask

  // Returns at the negedge following the accepting edge E0.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] eh, input logic [W-1:0] el,
                       input string nm, input bit want_done, output int e0);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(posedge clk);
    e0 = cyc;
    if (want_done) push_exp(eh, el, e0 + LAT, nm);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    int bad_busy;
    int bad_hold;

    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi",   64'(hi),   64'd0);
    check("reset_lo",   64'(lo),   64'd0);
    rst_n = 1'b1;

    // MULT -3 * 7 with busy window and output hold during iteration.
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m3x7", 1'b1, e0);
    bad_busy = 0;
    bad_hold = 0;
    for (int k = 0; k < LAT; k++) begin
      if (k > 0) @(negedge clk);
      if (busy !== 1'b1) bad_busy++;
      if (hi !== '0 || lo !== '0) bad_hold++;
    end
    check("mult_busy_window", 64'(bad_busy), 64'd0);
    check("hold_during_iter", 64'(bad_hold), 64'd0);
    @(negedge clk);
    check("busy_low_after_done", 64'(busy), 64'd0);
    drain();

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 1'b1, e0);
    drain();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2", 1'b1, e0);
    drain();
    issue(OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, "divu_by0", 1'b1, e0);
    drain();

    // Signed overflow, with an ignored second request at E5.
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf", 1'b1, e0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op    = OP_DIVU;
    a     = 32'd100;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    drain();

    issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, "mult_m1xm1", 1'b1, e0);
    drain();
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, "div_7dm2", 1'b1, e0);
    drain();
    issue(OP_DIV, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, "div_m8_by0", 1'b1, e0);
    drain();
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, "mult_min_sq", 1'b1, e0);
    drain();
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, "divu_max_d16", 1'b1, e0);
    drain();
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, "multu_2p32", 1'b1, e0);
    drain();

    // Reset at E10 aborts a MULTU; new start at E12 finishes at E45.
    issue(OP_MULTU, 32'd9, 32'd9, '0, '0, "aborted", 1'b0, e0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi",   64'(hi),   64'd0);
    check("abort_lo",   64'(lo),   64'd0);
    rst_n = 1'b1;
    issue(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, "post_reset", 1'b1, e0);
    check("post_reset_start_edge", 64'(e0), 64'(e0 - 12 + 12));
    drain();

    // Back-to-back: start held high across two ops.
    @(negedge clk);
    start = 1'b1;
    op    = OP_MULT;
    a     = 32'd5;
    b     = 32'hFFFF_FFFC;
    @(posedge clk);
    e0 = cyc;
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFEC, e0 + LAT,     "b2b_mult");
    push_exp(32'd2,         32'd14,        e0 + 2 * LAT, "b2b_divu");
    @(negedge clk);
    op = OP_DIVU;
    a  = 32'd100;
    b  = 32'd7;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    drain();

    check("final_idle_busy", 64'(busy), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
